// File: rtl/present_sequence.sv
// present_sequence: plays a latched four-symbol button sequence on three one-hot LEDs
module present_sequence #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int ON_TIME_US    = 250_000,
    parameter int GAP_TIME_US   = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] seq_in,
    output logic [2:0] leds_out,
    output logic [1:0] sym_idx,
    output logic       busy,
    output logic       done
);
    localparam int CPU     = CLK_FREQUENCY / 1_000_000;
    localparam int ON_CYC  = ON_TIME_US * CPU;
    localparam int GAP_CYC = GAP_TIME_US * CPU;
    localparam int MAX_CYC = ON_CYC > GAP_CYC ? ON_CYC : GAP_CYC;
    localparam int CW      = MAX_CYC > 1 ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ON   = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    logic [1:0]    state_q, state_d;
    logic [7:0]    seq_q, seq_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    leds_q, leds_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [1:0]    sym_d;
    // Sequencer: abort wins over start; each slot is ON_CYC lit cycles then GAP_CYC dark cycles
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ON: begin
                    cnt_d   = cnt_q == ON_LAST ? '0 : cnt_q + 1'b1;
                    state_d = cnt_q == ON_LAST ? GAP : ON;
                end
                GAP: begin
                    cnt_d   = cnt_q == GAP_LAST ? '0 : cnt_q + 1'b1;
                    state_d = cnt_q != GAP_LAST ? GAP : idx_q == 2'd3 ? DONE : ON;
                    idx_d   = cnt_q == GAP_LAST && idx_q != 2'd3 ? idx_q + 2'd1 : idx_q;
                end
                default: begin
                    if (start) begin
                        state_d = ON;
                        seq_d   = seq_in;
                        idx_d   = 2'd0;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
    end
    // Outputs are decoded from the next state so they register alongside it, giving one-cycle start latency
    always_comb begin
        sym_d  = seq_d[{idx_d, 1'b0} +: 2];
        leds_d = state_d == ON && sym_d != 2'd3 ? 3'b001 << sym_d : 3'b000;
        busy_d = state_d == ON || state_d == GAP;
        done_d = state_d == DONE;
    end
    // State and output registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            seq_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            leds_q  <= leds_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign leds_out = leds_q;
    assign sym_idx  = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_present_sequence.sv
// tb_present_sequence: checks playback timing, start/abort/reset handling against a slot-arithmetic model
module tb_present_sequence;
    localparam int FREQ   = 4_000_000;
    localparam int ON_US  = 2;
    localparam int GAP_US = 1;
    localparam int ON_C   = ON_US * (FREQ / 1_000_000);
    localparam int GAP_C  = GAP_US * (FREQ / 1_000_000);
    localparam int SLOT   = ON_C + GAP_C;
    localparam int DONE_K = 1 + 4 * SLOT;
    localparam logic [7:0] S1 = 8'b10_01_00_10;

    logic       clk = 1'b0;
    logic       reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [7:0] seq_in = 8'h00;
    logic [2:0] leds_out;
    logic [1:0] sym_idx;
    logic       busy, done;

    present_sequence #(.CLK_FREQUENCY(FREQ), .ON_TIME_US(ON_US), .GAP_TIME_US(GAP_US)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .seq_in(seq_in),
        .leds_out(leds_out), .sym_idx(sym_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    bit         m_run = 1'b0;
    int         m_k = 0;
    logic [7:0] m_seq = 8'h00;

    typedef struct {
        int         k;
        logic [2:0] leds;
        logic [1:0] idx;
        logic       busy;
        logic       done;
    } row_t;
    row_t tbl[13];

    function automatic logic [6:0] model_out();
        int slot, pos, sym;
        logic [2:0] l;
        if (!m_run) return 7'd0;
        if (m_k >= DONE_K) return {3'b000, 2'd3, 1'b0, 1'b1};
        slot = (m_k - 1) / SLOT;
        pos  = (m_k - 1) % SLOT;
        sym  = (m_seq >> (2 * slot)) & 3;
        l    = (pos < ON_C && sym != 3) ? 3'(1 << sym) : 3'b000;
        return {l, 2'(slot), 1'b1, 1'b0};
    endfunction

    task automatic model_edge();
        if (reset || abort) m_run = 1'b0;
        else if (start && (!m_run || m_k >= DONE_K)) begin
            m_run = 1'b1;
            m_k   = 1;
            m_seq = seq_in;
        end else if (m_run && m_k < DONE_K) m_k++;
    endtask

    task automatic chk(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {leds_out, sym_idx, busy, done};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got leds=%b idx=%0d busy=%b done=%b, want leds=%b idx=%0d busy=%b done=%b",
                     name, $time, act[6:4], act[3:2], act[1], act[0], exp[6:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", model_out());
    endtask

    task automatic table_at(input int k);
        foreach (tbl[i])
            if (tbl[i].k == k) chk($sformatf("table_k%0d", k), {tbl[i].leds, tbl[i].idx, tbl[i].busy, tbl[i].done});
    endtask

    task automatic pulse_start(input logic [7:0] s);
        start  = 1'b1;
        seq_in = s;
        tick();
        start  = 1'b0;
    endtask

    initial begin
        tbl = '{
            '{1,  3'b100, 2'd0, 1'b1, 1'b0}, '{8,  3'b100, 2'd0, 1'b1, 1'b0},
            '{9,  3'b000, 2'd0, 1'b1, 1'b0}, '{12, 3'b000, 2'd0, 1'b1, 1'b0},
            '{13, 3'b001, 2'd1, 1'b1, 1'b0}, '{20, 3'b001, 2'd1, 1'b1, 1'b0},
            '{21, 3'b000, 2'd1, 1'b1, 1'b0}, '{25, 3'b010, 2'd2, 1'b1, 1'b0},
            '{37, 3'b100, 2'd3, 1'b1, 1'b0}, '{45, 3'b000, 2'd3, 1'b1, 1'b0},
            '{48, 3'b000, 2'd3, 1'b1, 1'b0}, '{49, 3'b000, 2'd3, 1'b0, 1'b1},
            '{55, 3'b000, 2'd3, 1'b0, 1'b1}
        };
        tick();
        tick();
        chk("reset_state", 7'd0);
        reset = 1'b0;
        tick();
        chk("idle_after_reset", 7'd0);

        pulse_start(S1);
        table_at(1);
        seq_in = 8'hFF;
        for (int k = 2; k <= 55; k++) begin
            tick();
            table_at(k);
        end

        pulse_start(8'h00);
        chk("restart_from_done", {3'b001, 2'd0, 1'b1, 1'b0});
        for (int k = 2; k <= DONE_K; k++) tick();
        chk("restart_done", {3'b000, 2'd3, 1'b0, 1'b1});

        pulse_start(8'b11_11_11_00);
        chk("invalid_k1", {3'b001, 2'd0, 1'b1, 1'b0});
        for (int k = 2; k <= DONE_K; k++) begin
            tick();
            if (k == 9)  chk("invalid_k9",  {3'b000, 2'd0, 1'b1, 1'b0});
            if (k == 13) chk("invalid_k13", {3'b000, 2'd1, 1'b1, 1'b0});
            if (k == 37) chk("invalid_k37", {3'b000, 2'd3, 1'b1, 1'b0});
        end
        chk("invalid_done", {3'b000, 2'd3, 1'b0, 1'b1});

        pulse_start(S1);
        for (int k = 2; k <= DONE_K; k++) begin
            start  = k == 10;
            seq_in = k == 10 ? 8'b00_00_11_01 : S1;
            tick();
            table_at(k);
        end
        start = 1'b0;

        pulse_start(S1);
        for (int k = 2; k <= 29; k++) tick();
        chk("pre_abort_sym2", {3'b010, 2'd2, 1'b1, 1'b0});
        abort  = 1'b1;
        start  = 1'b1;
        seq_in = 8'b00_00_00_01;
        tick();
        chk("abort_wins", 7'd0);
        abort = 1'b0;
        start = 1'b0;
        tick();
        chk("abort_idle", 7'd0);
        pulse_start(S1);
        chk("replay_sym0", {3'b100, 2'd0, 1'b1, 1'b0});

        for (int k = 2; k <= 9; k++) tick();
        chk("pre_reset_gap", {3'b000, 2'd0, 1'b1, 1'b0});
        reset = 1'b1;
        tick();
        chk("reset_in_gap", 7'd0);
        start = 1'b1;
        tick();
        chk("start_during_reset", 7'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        chk("idle_after_reset2", 7'd0);

        for (int c = 0; c < 3000; c++) begin
            start  = $urandom_range(0, 15) == 0;
            abort  = $urandom_range(0, 79) == 0;
            reset  = $urandom_range(0, 299) == 0;
            seq_in = 8'($urandom);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
